// File: rtl/learning_session_ctrl.sv
// Song-learning session controller: song selection, play-session launch,
// hit/miss scoring and a per-song best-score table.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   next_song, prev_song       debounced level buttons, act on rising edge
//   start                      level button, rising edge launches a session
//   note_hit, note_miss        one-cycle pulses from the player
//   play_done                  one-cycle pulse from the player at song end
//   show_score                 level, selects display content
//   song_number                currently selected song
//   play_start                 one-cycle pulse launching the player
//   busy                       high while a session is playing or being scored
//   score, miss_count          counters of the current or last session
//   best_score                 stored best score for song_number (combinational)
//   new_record                 one-cycle pulse when a best score is replaced
//   display_sel                0 = song number, 1 = score
module learning_session_ctrl #(
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned SCORE_W   = 8,
  parameter bit          WRAP      = 1'b0,
  parameter int unsigned SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next_song,
  input  logic               prev_song,
  input  logic               start,
  input  logic               note_hit,
  input  logic               note_miss,
  input  logic               play_done,
  input  logic               show_score,
  output logic [SONG_W-1:0]  song_number,
  output logic               play_start,
  output logic               busy,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_count,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_record,
  output logic               display_sel
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    UPDATE = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam int unsigned        BTN_W     = 3;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SONG_W-1:0]  LAST_SONG = SONG_W'(NUM_SONGS - 1);

  state_t               state, state_d;
  logic [BTN_W-1:0]     btn_raw, btn_q, btn_qq, btn_evt;
  logic                 primed;
  logic                 next_evt, prev_evt, start_evt;
  logic [SONG_W-1:0]    song_d, song_inc, song_dec;
  logic [SCORE_W-1:0]   score_d, miss_d;
  logic                 play_start_d, new_record_d, busy_d, display_sel_d;
  logic                 best_we;
  logic [SCORE_W-1:0]   best_mem [NUM_SONGS];

  assign btn_raw = {start, prev_song, next_song};

  // Button edge detection; the first edge after reset seeds both stages with
  // the live level so a button held through reset release is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q  <= '0;
      btn_qq <= '0;
      primed <= 1'b0;
    end else begin
      btn_q  <= btn_raw;
      btn_qq <= primed ? btn_q : btn_raw;
      primed <= 1'b1;
    end
  end

  assign btn_evt   = btn_q & ~btn_qq;
  assign next_evt  = btn_evt[0];
  assign prev_evt  = btn_evt[1];
  assign start_evt = btn_evt[2];

  // Neighbouring song indices with wrap or saturation at the ends.
  assign song_inc = (song_number == LAST_SONG) ? (WRAP ? '0 : song_number)
                                               : song_number + SONG_W'(1);
  assign song_dec = (song_number == '0) ? (WRAP ? LAST_SONG : song_number)
                                        : song_number - SONG_W'(1);

  assign best_score = best_mem[song_number];

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    song_d       = song_number;
    score_d      = score;
    miss_d       = miss_count;
    play_start_d = 1'b0;
    new_record_d = 1'b0;
    best_we      = 1'b0;
    unique case (state)
      IDLE, SHOW: begin
        if (next_evt && !prev_evt) begin
          song_d = song_inc;
        end else if (prev_evt && !next_evt) begin
          song_d = song_dec;
        end
        if ((state == SHOW) && (next_evt || prev_evt)) begin
          state_d = IDLE;
        end
        if (start_evt) begin
          state_d      = PLAY;
          score_d      = '0;
          miss_d       = '0;
          play_start_d = 1'b1;
        end
      end
      PLAY: begin
        if (note_hit && (score != SCORE_MAX)) begin
          score_d = score + SCORE_W'(1);
        end
        if (note_miss && (miss_count != SCORE_MAX)) begin
          miss_d = miss_count + SCORE_W'(1);
        end
        // Compare with the hit of this cycle included so new_record lines up
        // with the single UPDATE cycle.
        if (play_done) begin
          state_d      = UPDATE;
          new_record_d = (score_d > best_mem[song_number]);
        end
      end
      UPDATE: begin
        state_d = SHOW;
        best_we = new_record;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d        = (state_d == PLAY) || (state_d == UPDATE);
    display_sel_d = show_score || (state_d == SHOW);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      song_number <= '0;
      score       <= '0;
      miss_count  <= '0;
      play_start  <= 1'b0;
      new_record  <= 1'b0;
      busy        <= 1'b0;
      display_sel <= 1'b0;
    end else begin
      state       <= state_d;
      song_number <= song_d;
      score       <= score_d;
      miss_count  <= miss_d;
      play_start  <= play_start_d;
      new_record  <= new_record_d;
      busy        <= busy_d;
      display_sel <= display_sel_d;
    end
  end

  // Best-score table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SONGS); i++) begin
        best_mem[i] <= '0;
      end
    end else if (best_we) begin
      best_mem[song_number] <= score;
    end
  end

endmodule

// File: tb/tb_learning_session_ctrl.sv
// Bench for learning_session_ctrl: three instances (saturating, wrapping,
// 4-bit score) share stimulus and are compared every cycle against a
// session-level reference model, plus directed constant checks.
module tb_learning_session_ctrl;

  localparam int NSONG  = 4;
  localparam int P_IDLE = 0;
  localparam int P_PLAY = 1;
  localparam int P_UPD  = 2;
  localparam int P_SHOW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic next_song = 1'b0, prev_song = 1'b0, start = 1'b0;
  logic note_hit = 1'b0, note_miss = 1'b0, play_done = 1'b0, show_score = 1'b0;

  logic [1:0] song0, song1, song2;
  logic [7:0] sc0, mc0, bs0, sc1, mc1, bs1;
  logic [3:0] sc2, mc2, bs2;
  logic       ps0, ps1, ps2, nr0, nr1, nr2, busy0, busy1, busy2, ds0, ds1, ds2;

  always #5 clk = ~clk;

  learning_session_ctrl #(.NUM_SONGS(4), .SCORE_W(8), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .next_song(next_song), .prev_song(prev_song),
    .start(start), .note_hit(note_hit), .note_miss(note_miss),
    .play_done(play_done), .show_score(show_score), .song_number(song0),
    .play_start(ps0), .busy(busy0), .score(sc0), .miss_count(mc0),
    .best_score(bs0), .new_record(nr0), .display_sel(ds0));

  learning_session_ctrl #(.NUM_SONGS(4), .SCORE_W(8), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .next_song(next_song), .prev_song(prev_song),
    .start(start), .note_hit(note_hit), .note_miss(note_miss),
    .play_done(play_done), .show_score(show_score), .song_number(song1),
    .play_start(ps1), .busy(busy1), .score(sc1), .miss_count(mc1),
    .best_score(bs1), .new_record(nr1), .display_sel(ds1));

  learning_session_ctrl #(.NUM_SONGS(4), .SCORE_W(4), .WRAP(1'b0)) u_s4 (
    .clk(clk), .reset(reset), .next_song(next_song), .prev_song(prev_song),
    .start(start), .note_hit(note_hit), .note_miss(note_miss),
    .play_done(play_done), .show_score(show_score), .song_number(song2),
    .play_start(ps2), .busy(busy2), .score(sc2), .miss_count(mc2),
    .best_score(bs2), .new_record(nr2), .display_sel(ds2));

  // Reference model state
  int  m_phase [3];
  int  m_song  [3];
  int  m_score [3];
  int  m_miss  [3];
  int  m_best  [3][NSONG];
  bit  m_ps    [3];
  bit  m_nr    [3];
  bit  m_busy  [3];
  bit  m_disp  [3];
  int  max_p   [3] = '{255, 255, 15};
  bit  wrap_p  [3] = '{1'b0, 1'b1, 1'b0};
  bit [2:0] h1, h2;
  bit  first_edge;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ps_cnt [3];
  int nr_cnt [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = P_IDLE; m_song[i] = 0; m_score[i] = 0; m_miss[i] = 0;
      m_ps[i] = 1'b0; m_nr[i] = 1'b0; m_busy[i] = 1'b0; m_disp[i] = 1'b0;
      for (int s = 0; s < NSONG; s++) m_best[i][s] = 0;
    end
    h1 = '0; h2 = '0; first_edge = 1'b1;
  endtask

  task automatic model_inst(input int i, input bit en, input bit ep, input bit es);
    int s;
    s = m_song[i];
    m_ps[i] = 1'b0;
    m_nr[i] = 1'b0;
    case (m_phase[i])
      P_IDLE, P_SHOW: begin
        if (en && !ep) s = (s == NSONG - 1) ? (wrap_p[i] ? 0 : s) : s + 1;
        else if (ep && !en) s = (s == 0) ? (wrap_p[i] ? NSONG - 1 : 0) : s - 1;
        m_song[i] = s;
        if (m_phase[i] == P_SHOW && (en || ep)) m_phase[i] = P_IDLE;
        if (es) begin
          m_phase[i] = P_PLAY; m_score[i] = 0; m_miss[i] = 0; m_ps[i] = 1'b1;
        end
      end
      P_PLAY: begin
        if (note_hit)  m_score[i] = (m_score[i] < max_p[i]) ? m_score[i] + 1 : m_score[i];
        if (note_miss) m_miss[i]  = (m_miss[i]  < max_p[i]) ? m_miss[i] + 1  : m_miss[i];
        if (play_done) begin
          m_phase[i] = P_UPD;
          m_nr[i] = (m_score[i] > m_best[i][m_song[i]]);
        end
      end
      default: begin
        if (m_score[i] > m_best[i][m_song[i]]) m_best[i][m_song[i]] = m_score[i];
        m_phase[i] = P_SHOW;
      end
    endcase
    m_busy[i] = (m_phase[i] == P_PLAY) || (m_phase[i] == P_UPD);
    m_disp[i] = show_score || (m_phase[i] == P_SHOW);
  endtask

  // Button press seen high at edge k and low at edge k-1 acts at edge k+1.
  task automatic model_edge();
    bit [2:0] cur, ev;
    if (reset) return;
    cur = {start, prev_song, next_song};
    ev  = h1 & ~h2;
    for (int i = 0; i < 3; i++) model_inst(i, ev[0], ev[1], ev[2]);
    if (first_edge) begin
      h1 = cur; h2 = cur; first_edge = 1'b0;
    end else begin
      h2 = h1; h1 = cur;
    end
  endtask

  function automatic logic [29:0] get_obs(input int i);
    case (i)
      0:       return {song0, sc0, mc0, bs0, ps0, nr0, busy0, ds0};
      1:       return {song1, sc1, mc1, bs1, ps1, nr1, busy1, ds1};
      default: return {song2, 4'b0, sc2, 4'b0, mc2, 4'b0, bs2, ps2, nr2, busy2, ds2};
    endcase
  endfunction

  function automatic logic [29:0] get_exp(input int i);
    return {2'(m_song[i]), 8'(m_score[i]), 8'(m_miss[i]), 8'(m_best[i][m_song[i]]),
            m_ps[i], m_nr[i], m_busy[i], m_disp[i]};
  endfunction

  task automatic check_inst(input int i);
    logic [29:0] obs, exp;
    obs = get_obs(i);
    exp = get_exp(i);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL model inst%0d cyc%0d observed=%h expected=%h", i, cyc, obs, exp);
    end
  endtask

  task automatic check_const(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) check_inst(i);
    ps_cnt[0] += int'(ps0); ps_cnt[1] += int'(ps1); ps_cnt[2] += int'(ps2);
    nr_cnt[0] += int'(nr0); nr_cnt[1] += int'(nr1); nr_cnt[2] += int'(nr2);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) check_inst(i);
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press(input bit n, input bit p, input bit s);
    next_song = n; prev_song = p; start = s;
    tick();
    tick();
    next_song = 1'b0; prev_song = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic hits(input int n);
    note_hit = 1'b1;
    ticks(n);
    note_hit = 1'b0;
  endtask

  task automatic finish_session();
    play_done = 1'b1;
    tick();
    play_done = 1'b0;
    ticks(2);
  endtask

  initial begin
    int exp_sat [5] = '{1, 2, 3, 3, 3};
    int exp_wrp [5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 3; i++) begin ps_cnt[i] = 0; nr_cnt[i] = 0; end
    #2;
    do_reset();
    check_const("rst_song", 32'(song0), 0);
    check_const("rst_busy", 32'(busy0), 0);
    check_const("rst_disp", 32'(ds0), 0);

    // Song selection saturating vs wrapping
    for (int k = 0; k < 5; k++) begin
      press(1'b1, 1'b0, 1'b0);
      check_const($sformatf("sat_next%0d", k), 32'(song0), 32'(exp_sat[k]));
      check_const($sformatf("wrap_next%0d", k), 32'(song1), 32'(exp_wrp[k]));
    end
    press(1'b0, 1'b1, 1'b0);
    check_const("sat_prev", 32'(song0), 2);
    check_const("wrap_prev", 32'(song1), 0);

    // Button held through reset release is not an event
    next_song = 1'b1;
    do_reset();
    ticks(3);
    next_song = 1'b0;
    ticks(2);
    check_const("held_reset_song", 32'(song0), 0);

    // Wrap at both ends, simultaneous next+prev
    press(1'b0, 1'b1, 1'b0);
    check_const("wrap_prev_at0", 32'(song1), 3);
    check_const("sat_prev_at0", 32'(song0), 0);
    press(1'b1, 1'b0, 1'b0);
    check_const("wrap_next_at3", 32'(song1), 0);
    press(1'b1, 1'b1, 1'b0);
    check_const("wrap_both", 32'(song1), 0);
    check_const("sat_both", 32'(song0), 1);

    // Session on song 1: 5 hits, 2 misses
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    nr_cnt[0] = 0;
    press(1'b0, 1'b0, 1'b1);
    hits(5);
    note_miss = 1'b1; ticks(2); note_miss = 1'b0;
    finish_session();
    check_const("sess_score", 32'(sc0), 5);
    check_const("sess_miss", 32'(mc0), 2);
    check_const("sess_nr_cnt", 32'(nr_cnt[0]), 1);
    check_const("sess_best", 32'(bs0), 5);
    check_const("sess_show_disp", 32'(ds0), 1);
    check_const("sess_show_busy", 32'(busy0), 0);
    nr_cnt[0] = 0;
    press(1'b0, 1'b0, 1'b1);
    hits(5);
    finish_session();
    check_const("equal_nr_cnt", 32'(nr_cnt[0]), 0);
    check_const("equal_best", 32'(bs0), 5);

    // Score saturation and hit coincident with play_done
    do_reset();
    press(1'b0, 1'b0, 1'b1);
    hits(20);
    check_const("sat4_score", 32'(sc2), 15);
    check_const("w8_score20", 32'(sc0), 20);
    finish_session();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    hits(9);
    note_hit = 1'b1; play_done = 1'b1;
    tick();
    note_hit = 1'b0; play_done = 1'b0;
    ticks(2);
    check_const("coinc_best_s4", 32'(bs2), 10);
    check_const("coinc_best_w8", 32'(bs0), 10);

    // Reset in the middle of a session
    press(1'b0, 1'b0, 1'b1);
    hits(3);
    check_const("mid_score", 32'(sc0), 3);
    do_reset();
    check_const("mid_rst_score", 32'(sc0), 0);
    check_const("mid_rst_best", 32'(bs0), 0);
    check_const("mid_rst_busy", 32'(busy0), 0);
    ps_cnt[0] = 0;
    press(1'b0, 1'b0, 1'b1);
    ticks(3);
    check_const("mid_rst_ps_cnt", 32'(ps_cnt[0]), 1);

    // Start held, song change ignored during play
    do_reset();
    ps_cnt[0] = 0;
    start = 1'b1;
    ticks(2);
    next_song = 1'b1; ticks(2); next_song = 1'b0;
    ticks(6);
    start = 1'b0;
    check_const("play_song", 32'(song0), 0);
    check_const("play_ps_cnt", 32'(ps_cnt[0]), 1);
    check_const("play_busy", 32'(busy0), 1);
    play_done = 1'b1; tick(); play_done = 1'b0;
    check_const("upd_busy", 32'(busy0), 1);
    tick();
    check_const("show_busy", 32'(busy0), 0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      next_song  = next_song  ^ ($urandom_range(0, 9) == 0);
      prev_song  = prev_song  ^ ($urandom_range(0, 9) == 0);
      start      = start      ^ ($urandom_range(0, 11) == 0);
      show_score = show_score ^ ($urandom_range(0, 7) == 0);
      note_hit   = ($urandom_range(0, 2) == 0);
      note_miss  = ($urandom_range(0, 3) == 0);
      play_done  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
